nios2_cpu_debug_jtag_initiator: RTL
===================================

# nios2_cpu_debug_jtag_initiator

Clock-domain JTAG initiator that drives the virtual-JTAG side of the Nios II CPU debug slave. It accepts one debug command (2-bit IR, 38-bit DR word) per handshake and sequences the virtual states UIR → CDR → SDR×DR_WIDTH → UDR (→ RTI) on a generated TCK. It returns the word shifted out on TDO. It sits in the on-chip debug path and in benches, in place of the SLD hub, feeding the debug slave's tck/sysclk logic.

## Interface
- TCK_DIV, 2: clk cycles per TCK half-period; legal range ≥1.
- DR_WIDTH, 38: data-register length in bits.
- RTI_CYCLES, 4: TCK periods spent in RTI after UDR; legal range 1–15. Used only with NIOS_DBG_INIT_RTI_EN.
- clk in 1: sole clock; all logic is rising-edge.
- reset in 1: synchronous, active-high.
- cmd_valid in 1: command request.
- cmd_ready out 1: high only in IDLE.
- cmd_ir in 2: IR value for the command.
- cmd_data in DR_WIDTH: DR value, shifted LSB first.
- rsp_valid out 1: one-cycle pulse; no backpressure.
- rsp_data out DR_WIDTH: captured TDO word; valid with rsp_valid and held until the next accept.
- tck out 1: generated JTAG clock.
- tdi out 1: serial data to slave.
- tdo in 1: serial data from slave.
- ir_in out 2: IR presented to slave.
- vs_uir, vs_cdr, vs_sdr, vs_udr out 1 each: virtual-state indicators.
- jtag_state_rti out 1: run-test-idle indicator.

## Operation
- FSM states are IDLE, UIR, CDR, SDR, UDR, RTI.
- Each non-IDLE state lasts exactly one TCK period (2·TCK_DIV clk cycles), except:
  - SDR lasts DR_WIDTH periods.
  - RTI lasts RTI_CYCLES periods.
- Accept occurs on a clk edge with cmd_valid & cmd_ready. On accept:
  - latch cmd_data into the shift register;
  - latch cmd_ir into ir_in;
  - enter UIR.
- ir_in is held from UIR until the next accept.
- Exactly one vs_*/jtag_state_rti output is high per non-IDLE state, for the whole state duration. All of them are 0 in IDLE.
- SDR shifting:
  - tdi = shift_reg[0];
  - tdo is sampled at the TCK rising point into bit DR_WIDTH-1 while the register shifts right;
  - after DR_WIDTH shifts, rsp_data[0] holds the first-sampled tdo bit.
- tdi is 0 outside SDR.
- Transitions:
  - UDR → RTI (macro defined) or UDR → IDLE (macro undefined);
  - RTI → IDLE.
  - rsp_valid pulses in the first IDLE cycle after the final period.
- cmd_valid while busy is ignored; the command stays pending until cmd_ready.
- Divider counter counts 0..TCK_DIV-1 per half-period; width is ceil(log2(TCK_DIV))+1.

## Timing
- TCK period: tck is 0 for the first TCK_DIV cycles and 1 for the next TCK_DIV cycles.
- State outputs and tdi change only on the clk edge that starts a period (TCK falling).
- tdo is sampled on the clk edge where tck goes 0→1.
- Let N = 3 + DR_WIDTH + (RTI_CYCLES if macro defined, else 0).
  - State UIR begins 1 cycle after the accept edge.
  - rsp_valid is high in cycle 1 + N·2·TCK_DIV counted from the accept edge.
  - cmd_ready rises in that same cycle. The earliest next accept is that cycle's edge.
- Reset values:
  - state IDLE, cmd_ready=1;
  - tck, tdi, all vs_*, jtag_state_rti, rsp_valid = 0;
  - ir_in=0, rsp_data=0, divider=0.
- Reset mid-command: the next cycle is IDLE with all reset values. No rsp_valid is produced for the aborted command.
- Reset takes priority over accept when both occur in the same cycle.

## Configuration
- NIOS_DBG_INIT_RTI_EN defined:
  - RTI state is compiled in;
  - jtag_state_rti is high for RTI_CYCLES periods after UDR, so the slave can assert st_ready_test_idle.
- NIOS_DBG_INIT_RTI_EN undefined:
  - RTI state and its counter are absent;
  - jtag_state_rti is tied 0;
  - UDR → IDLE directly;
  - N = 3 + DR_WIDTH.

## Test plan
- Reset then idle, defaults, macro undefined: cmd_ready=1, all outputs 0. Issue cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A with tdo looped to tdi → rsp_valid at cycle 165, rsp_data=38'h2A_5A5A_5A5A, ir_in=2'b01.
- Same command with macro defined, RTI_CYCLES=4 → jtag_state_rti high for exactly 16 clk, rsp_valid at cycle 181.
- tdo tied 1, cmd_data=0, TCK_DIV=1 → tdi never 1, rsp_data=38'h3F_FFFF_FFFF, rsp_valid at cycle 83 (macro undefined).
- Assert reset during SDR bit 10 → next cycle IDLE, tck=0, vs_sdr=0, no rsp_valid. A following command completes normally.
- Hold cmd_valid continuously with two queued commands → second accept on the rsp_valid cycle. Per command, the bench counts exactly one vs_uir, one vs_cdr, DR_WIDTH·2·TCK_DIV vs_sdr cycles, and one vs_udr period.
- Waveform checks across all scenarios:
  - tdi changes only on tck-falling edges;
  - exactly one state indicator is high per non-IDLE cycle.

Source files
------------

// File: rtl/nios2_cpu_debug_jtag_initiator.sv
// +---------------------------------------------------------------------------+
// | nios2_cpu_debug_jtag_initiator: clk-domain virtual-JTAG command sequencer |
// | Optional RTI dwell after UDR: NIOS_DBG_INIT_RTI_EN.   Rev 1.0            |
// +---------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module nios2_cpu_debug_jtag_initiator #(
  parameter int TCK_DIV    = 2,
  parameter int DR_WIDTH   = 38,
  parameter int RTI_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [1:0]          ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int DIV_W   = $clog2(TCK_DIV) + 1;
  localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] c_sdr_last = CNT_W'(DR_WIDTH - 1);

`ifdef NIOS_DBG_INIT_RTI_EN
  localparam logic [CNT_W-1:0] c_rti_last = CNT_W'(RTI_CYCLES - 1);
  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR} state_t;
`endif

  state_t               r_state, w_next;
  logic [DIV_W-1:0]     r_div;
  logic [CNT_W-1:0]     r_per;
  logic                 r_tck, r_tdi, r_rsp_valid;
  logic [1:0]           r_ir;
  logic [DR_WIDTH-1:0]  r_shift, r_rsp_data;
  logic                 w_half_end, w_period_end, w_rise;

  assign w_half_end   = (r_div == c_div_last);
  assign w_period_end = w_half_end & r_tck;
  assign w_rise       = w_half_end & ~r_tck;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = S_UIR;
      S_UIR:  if (w_period_end) w_next = S_CDR;
      S_CDR:  if (w_period_end) w_next = S_SDR;
      S_SDR:  if (w_period_end && (r_per == c_sdr_last)) w_next = S_UDR;
      S_UDR:  if (w_period_end) begin
`ifdef NIOS_DBG_INIT_RTI_EN
        w_next = S_RTI;
`else
        w_next = S_IDLE;
`endif
      end
`ifdef NIOS_DBG_INIT_RTI_EN
      S_RTI:  if (w_period_end && (r_per == c_rti_last)) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div       <= '0;
      r_per       <= '0;
      r_tck       <= 1'b0;
      r_tdi       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ir        <= 2'b00;
      r_shift     <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        r_div <= '0;
        r_per <= '0;
        r_tck <= 1'b0;
        r_tdi <= 1'b0;
        if (cmd_valid) begin
          r_shift <= cmd_data;
          r_ir    <= cmd_ir;
        end
      end else begin
        if (w_half_end) begin
          r_div <= '0;
          r_tck <= ~r_tck;
        end else begin
          r_div <= r_div + 1'b1;
        end
        // tdo is captured at TCK rise; tdi only moves at the following fall
        if (w_rise && (r_state == S_SDR))
          r_shift <= {tdo, r_shift[DR_WIDTH-1:1]};
        if (w_period_end) begin
          r_per <= (w_next != r_state) ? '0 : r_per + 1'b1;
          r_tdi <= (w_next == S_SDR) ? r_shift[0] : 1'b0;
          if (w_next == S_IDLE) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_shift;
          end
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign tck       = r_tck;
  assign tdi       = r_tdi;
  assign ir_in     = r_ir;
  assign vs_uir    = (r_state == S_UIR);
  assign vs_cdr    = (r_state == S_CDR);
  assign vs_sdr    = (r_state == S_SDR);
  assign vs_udr    = (r_state == S_UDR);
`ifdef NIOS_DBG_INIT_RTI_EN
  assign jtag_state_rti = (r_state == S_RTI);
`else
  assign jtag_state_rti = 1'b0;
`endif

endmodule

`default_nettype wire
